traffic_light_monitor: RTL and testbench

Passive observer on the output side of the traffic-light controller. It samples the red/green/yellow lamp lines and the countdown bus every clock and tracks the phase sequence. It measures each phase length and raises sticky error flags on illegal lamp codes, wrong phase order, wrong phase length or a broken countdown. It also counts completed light cycles. It serves both as a bench checker and as an on-chip health monitor.

---
 rtl/tl_pkg.sv | 25 ++
 rtl/tl_phase_decode.sv | 23 ++
 rtl/traffic_light_monitor.sv | 123 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared traffic-light phase encoding, default timing and ordering
package tl_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_t;

  localparam int RED_T    = 20;
  localparam int GREEN_T  = 15;
  localparam int YELLOW_T = 5;

  // Legal successor of each lamp phase; SYNC has no successor.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:    next_phase = PH_GREEN;
      PH_GREEN:  next_phase = PH_YELLOW;
      PH_YELLOW: next_phase = PH_RED;
      default:   next_phase = PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// rtl/tl_phase_decode.sv - lamp lines to {valid, phase}, combinational
module tl_phase_decode
  import tl_pkg::*;
(
  input  logic   red,
  input  logic   green,
  input  logic   yellow,
  output logic   valid,
  output phase_t ph
);

  always_comb begin
    valid = 1'b0;
    ph    = PH_SYNC;
    case ({red, green, yellow})
      3'b100: begin valid = 1'b1; ph = PH_RED;    end
      3'b010: begin valid = 1'b1; ph = PH_GREEN;  end
      3'b001: begin valid = 1'b1; ph = PH_YELLOW; end
      default: begin valid = 1'b0; ph = PH_SYNC;  end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive lamp/countdown checker with sticky error flags
module traffic_light_monitor #(
  parameter int RED_T    = tl_pkg::RED_T,
  parameter int GREEN_T  = tl_pkg::GREEN_T,
  parameter int YELLOW_T = tl_pkg::YELLOW_T,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          red,
  input  logic          green,
  input  logic          yellow,
  input  logic [CW-1:0] cnt_in,
  output logic [1:0]    phase,
  output logic [CW-1:0] phase_len,
  output logic [7:0]    cycles_done,
  output logic          err_onehot,
  output logic          err_order,
  output logic          err_len,
  output logic          err_cnt,
  output logic          err_any
);
  import tl_pkg::*;

  logic          valid;
  phase_t        obs_ph;
  phase_t        phase_q, phase_n;
  logic [CW-1:0] dur_q, dur_n, prev_q, prev_n, len_q, len_n, req_len;
  logic          partial_q, partial_n;
  logic [7:0]    cyc_q, cyc_n;
  logic          e_oh_q, e_oh_n, e_ord_q, e_ord_n, e_len_q, e_len_n, e_cnt_q, e_cnt_n;
  logic          legal;

  tl_phase_decode u_decode (
    .red    (red),
    .green  (green),
    .yellow (yellow),
    .valid  (valid),
    .ph     (obs_ph)
  );

  always_comb begin
    case (phase_q)
      PH_RED:    req_len = CW'(RED_T);
      PH_GREEN:  req_len = CW'(GREEN_T);
      PH_YELLOW: req_len = CW'(YELLOW_T);
      default:   req_len = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_SYNC;
      dur_q     <= '0;
      prev_q    <= '0;
      len_q     <= '0;
      partial_q <= 1'b1;
      cyc_q     <= '0;
      e_oh_q    <= 1'b0;
      e_ord_q   <= 1'b0;
      e_len_q   <= 1'b0;
      e_cnt_q   <= 1'b0;
    end else begin
      phase_q   <= phase_n;
      dur_q     <= dur_n;
      prev_q    <= prev_n;
      len_q     <= len_n;
      partial_q <= partial_n;
      cyc_q     <= cyc_n;
      e_oh_q    <= e_oh_n;
      e_ord_q   <= e_ord_n;
      e_len_q   <= e_len_n;
      e_cnt_q   <= e_cnt_n;
    end
  end

  always_comb begin
    phase_n   = phase_q;
    dur_n     = dur_q;
    prev_n    = prev_q;
    len_n     = len_q;
    partial_n = partial_q;
    cyc_n     = cyc_q;
    e_oh_n    = e_oh_q;
    e_ord_n   = e_ord_q;
    e_len_n   = e_len_q;
    e_cnt_n   = e_cnt_q;
    legal     = (obs_ph == next_phase(phase_q));
    if (!valid) begin
      e_oh_n = 1'b1;
    end else if (phase_q == PH_SYNC) begin
      phase_n   = obs_ph;
      dur_n     = CW'(1);
      partial_n = 1'b1;
      prev_n    = cnt_in;
    end else if (obs_ph == phase_q) begin
      if (dur_q != '1) dur_n = dur_q + CW'(1);
      if (prev_q == '0 || cnt_in != prev_q - CW'(1)) e_cnt_n = 1'b1;
      prev_n = cnt_in;
    end else begin
      len_n = dur_q;
      if (!partial_q && dur_q != req_len) e_len_n = 1'b1;
      if (!legal) e_ord_n = 1'b1;
      // A cycle only counts when it closes a fully observed yellow phase.
      if (legal && phase_q == PH_YELLOW && !partial_q && cyc_q != 8'd255)
        cyc_n = cyc_q + 8'd1;
      phase_n   = obs_ph;
      dur_n     = CW'(1);
      partial_n = 1'b0;
      prev_n    = cnt_in;
    end
  end

  assign phase       = phase_q;
  assign phase_len   = len_q;
  assign cycles_done = cyc_q;
  assign err_onehot  = e_oh_q;
  assign err_order   = e_ord_q;
  assign err_len     = e_len_q;
  assign err_cnt     = e_cnt_q;
  assign err_any     = e_oh_q | e_ord_q | e_len_q | e_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

  localparam int CW = 6;
  localparam logic [2:0] L_R = 3'b100, L_G = 3'b010, L_Y = 3'b001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          red = 1'b0, green = 1'b0, yellow = 1'b0;
  logic [CW-1:0] cnt_in = '0;
  logic [1:0]    phase;
  logic [CW-1:0] phase_len;
  logic [7:0]    cycles_done;
  logic          err_onehot, err_order, err_len, err_cnt, err_any;

  int n_cmp = 0;
  int n_mis = 0;

  traffic_light_monitor #(.RED_T(20), .GREEN_T(15), .YELLOW_T(5), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .red         (red),
    .green       (green),
    .yellow      (yellow),
    .cnt_in      (cnt_in),
    .phase       (phase),
    .phase_len   (phase_len),
    .cycles_done (cycles_done),
    .err_onehot  (err_onehot),
    .err_order   (err_order),
    .err_len     (err_len),
    .err_cnt     (err_cnt),
    .err_any     (err_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; the rising edge in between samples the inputs.
  task automatic cyc(input logic [2:0] lamps, input int c);
    {red, green, yellow} = lamps;
    cnt_in = CW'(c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] lamps, input int n, input int start);
    for (int i = 0; i < n; i++) cyc(lamps, start - i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_len", phase_len, 0);
    check("rst_cycles", cycles_done, 0);
    check("rst_err_any", err_any, 0);
    do_reset();

    // Legal run with a partial leading red
    run(L_R, 3, 2);
    check("legal_partial_len", phase, 1);
    run(L_G, 15, 14);
    run(L_Y, 5, 4);
    run(L_R, 20, 19);
    check("legal_cycles_1", cycles_done, 1);
    run(L_G, 15, 14);
    run(L_Y, 5, 4);
    cyc(L_R, 19);
    check("legal_cycles_2", cycles_done, 2);
    check("legal_phase_len", phase_len, 5);
    check("legal_phase", phase, 1);
    check("legal_err_any", err_any, 0);

    // Green held 14 cycles
    do_reset();
    run(L_R, 2, 1);
    run(L_G, 14, 13);
    check("short_g_pre", err_len, 0);
    cyc(L_Y, 4);
    check("short_g_err_len", err_len, 1);
    check("short_g_len", phase_len, 14);
    check("short_g_onehot", err_onehot, 0);
    check("short_g_order", err_order, 0);
    check("short_g_cnt", err_cnt, 0);

    // Red -> yellow skips green
    do_reset();
    run(L_R, 2, 1);
    run(L_Y, 5, 4);
    check("order_err", err_order, 1);
    cyc(L_R, 19);
    check("order_cycles", cycles_done, 1);
    check("order_err_len", err_len, 0);
    check("order_err_cnt", err_cnt, 0);

    // Illegal lamp code mid-green freezes duration
    do_reset();
    cyc(L_R, 0);
    run(L_G, 5, 14);
    cyc(3'b110, 9);
    check("oh_err", err_onehot, 1);
    check("oh_err_any", err_any, 1);
    check("oh_phase_held", phase, 2);
    run(L_G, 10, 9);
    cyc(L_Y, 4);
    check("oh_len", phase_len, 15);
    check("oh_err_len", err_len, 0);
    check("oh_err_cnt", err_cnt, 0);
    run(L_Y, 4, 3);
    check("oh_sticky", err_any, 1);

    // Countdown repeats
    do_reset();
    run(L_R, 2, 9);
    check("cnt_ok", err_cnt, 0);
    cyc(L_R, 8);
    check("cnt_repeat", err_cnt, 1);
    do_reset();
    cyc(L_R, 0);
    cyc(L_R, 0);
    check("cnt_zero", err_cnt, 1);

    // Asynchronous reset mid-yellow
    do_reset();
    cyc(L_R, 0);
    run(L_G, 14, 13);
    run(L_Y, 2, 4);
    check("arst_pre_err", err_any, 1);
    check("arst_pre_len", phase_len, 14);
    #2 rst = 1'b1;
    #1;
    check("arst_phase", phase, 0);
    check("arst_len", phase_len, 0);
    check("arst_err_any", err_any, 0);
    check("arst_cycles", cycles_done, 0);
    @(negedge clk);
    rst = 1'b0;
    run(L_Y, 3, 2);
    cyc(L_R, 19);
    check("post_partial_len", err_len, 0);
    check("post_partial_cycles", cycles_done, 0);
    check("post_partial_order", err_order, 0);
    run(L_R, 19, 18);
    cyc(L_G, 14);
    check("post_red_len", phase_len, 20);
    check("post_err_any", err_any, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
